// File: rtl/audio_rec_pkg.sv
// audio_rec_pkg: shared states, rate constants and sizing helper for the audio sample recorder.
package audio_rec_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        RECORD = 2'd2
    } rec_state_t;

    localparam int DIV_48KHZ = 260;
    localparam int SAMPLE_W  = 8;
    localparam int MIDSCALE  = 1 << (SAMPLE_W - 1);

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/audio_rec_ram.sv
// audio_rec_ram: simple dual-port sample RAM, one write port and one registered read port (old data on collision).
module audio_rec_ram
    import audio_rec_pkg::*;
#(
    parameter int DEPTH  = 4096,
    parameter int DATA_W = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      we_i,
    input  logic [addr_w(DEPTH)-1:0]  wr_addr_i,
    input  logic [DATA_W-1:0]         wr_data_i,
    input  logic [addr_w(DEPTH)-1:0]  rd_addr_i,
    output logic [DATA_W-1:0]         rd_data_o
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk_i) begin
        if (we_i) r_mem[wr_addr_i] <= wr_data_i;
    end

    // Only the output register is reset; the array keeps its contents.
    always_ff @(posedge clk_i) begin
        r_rd_data <= rst_i ? '0 : r_mem[rd_addr_i];
    end

    assign rd_data_o = r_rd_data;

endmodule

// File: rtl/audio_sample_recorder.sv
// audio_sample_recorder: records unsigned PCM at the divided sample rate into RAM with synchronous readback.
// Define AUDIO_REC_TRIGGER_EN to arm on start and begin recording once |sample - midscale| >= thresh_i.
module audio_sample_recorder
    import audio_rec_pkg::*;
#(
    parameter int CLK_DIV = DIV_48KHZ,
    parameter int DEPTH   = 4096,
    parameter int DATA_W  = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [DATA_W-1:0]          sample_i,
    input  logic                       rec_start_i,
    input  logic                       rec_stop_i,
    input  logic [DATA_W-2:0]          thresh_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr_i,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [$clog2(DEPTH):0]     rec_len_o
);

    localparam int AW = addr_w(DEPTH);
    localparam int DW = addr_w(CLK_DIV);

    rec_state_t    r_state, w_state_nxt;
    logic [DW-1:0] r_div;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_len;
    logic          r_busy, r_done;
    logic          w_tick, w_start, w_clear, w_we, w_done_nxt;

    assign w_tick  = r_div == DW'(CLK_DIV - 1);
    assign w_start = rec_start_i && !rec_stop_i;

`ifdef AUDIO_REC_TRIGGER_EN
    localparam logic [DATA_W-1:0] MID = DATA_W'(1) << (DATA_W - 1);
    localparam rec_state_t START_STATE = ARMED;
    logic [DATA_W-1:0] w_dev;
    logic              w_hit;
    assign w_dev = (sample_i >= MID) ? sample_i - MID : MID - sample_i;
    assign w_hit = w_dev >= {1'b0, thresh_i};
`else
    localparam rec_state_t START_STATE = RECORD;
    logic w_unused_thresh;
    assign w_unused_thresh = ^thresh_i;
`endif

    // Stop always beats a coincident tick, so the sample in that cycle is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_we        = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = START_STATE;
                end
            end
`ifdef AUDIO_REC_TRIGGER_EN
            ARMED: begin
                if (rec_stop_i) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else if (w_tick && w_hit) begin
                    w_we        = 1'b1;
                    w_state_nxt = RECORD;
                end
            end
`endif
            RECORD: begin
                if (rec_stop_i) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else if (w_tick) begin
                    w_we = 1'b1;
                    if (r_len == (AW + 1)'(DEPTH - 1)) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_div    <= '0;
            r_wr_ptr <= '0;
            r_len    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_tick ? '0 : r_div + 1'b1;
            r_busy  <= w_state_nxt != IDLE;
            r_done  <= w_done_nxt;
            if (w_clear) begin
                r_wr_ptr <= '0;
                r_len    <= '0;
            end else if (w_we) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_len    <= r_len + 1'b1;
            end
        end
    end

    audio_rec_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we_i      (w_we),
        .wr_addr_i (r_wr_ptr),
        .wr_data_i (sample_i),
        .rd_addr_i (rd_addr_i),
        .rd_data_o (rd_data_o)
    );

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign rec_len_o = r_len;

endmodule

// File: tb/tb_audio_sample_recorder.sv
// tb_audio_sample_recorder: directed scenarios for the recorder with CLK_DIV=4, DEPTH=16.
module tb_audio_sample_recorder;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 16;
    localparam int DATA_W  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rec_start = 1'b0;
    logic       rec_stop = 1'b0;
    logic [7:0] sample = 8'h00;
    logic [6:0] thresh = 7'h20;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_data;
    logic       busy, done;
    logic [4:0] rec_len;

    int checks = 0;
    int failures = 0;
    int m_div = 0;

    audio_sample_recorder #(
        .CLK_DIV (CLK_DIV),
        .DEPTH   (DEPTH),
        .DATA_W  (DATA_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .sample_i    (sample),
        .rec_start_i (rec_start),
        .rec_stop_i  (rec_stop),
        .thresh_i    (thresh),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .busy_o      (busy),
        .done_o      (done),
        .rec_len_o   (rec_len)
    );

    always #5 clk = ~clk;

    // Free-running tick phase as seen by the bench: a tick edge ends each cycle where m_div == CLK_DIV-1.
    always @(posedge clk) m_div <= rst ? 0 : (m_div == CLK_DIV - 1 ? 0 : m_div + 1);

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        rec_start = 1'b1;
        step();
        rec_start = 1'b0;
    endtask

    task automatic run_ticks(input int n, input logic [7:0] base);
        int k = 0;
        for (int c = 0; c < n * CLK_DIV + CLK_DIV && k < n; c++) begin
            if (m_div == CLK_DIV - 1) begin
                sample = base + 8'(k);
                k++;
            end
            step();
        end
        checks++;
        if (k != n) begin
            failures++;
            $display("FAIL run_ticks got=%0d ticks exp=%0d", k, n);
        end
    endtask

    task automatic wait_tick_cycle();
        for (int c = 0; c < CLK_DIV && m_div != CLK_DIV - 1; c++) step();
    endtask

    task automatic test_reset();
        step();
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (rec_len !== 5'd0) begin failures++; $display("FAIL reset_len got=%0d exp=0", rec_len); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd got=%0h exp=0", rd_data); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        pulse_start();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_rise got=%0b exp=1", busy); end
        run_ticks(8, 8'h10);
        checks++; if (rec_len !== 5'd8) begin failures++; $display("FAIL basic_len_mid got=%0d exp=8", rec_len); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_early got=%0b exp=0", done); end
        run_ticks(8, 8'h18);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL basic_done got=%0b exp=1", done); end
        step();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_once got=%0b exp=0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_fall got=%0b exp=0", busy); end
        for (int i = 0; i < 8; i++) step();
        checks++; if (rec_len !== 5'd16) begin failures++; $display("FAIL basic_len_full got=%0d exp=16", rec_len); end
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = 4'(a);
            step();
            checks++;
            if (rd_data !== 8'h10 + 8'(a)) begin
                failures++;
                $display("FAIL basic_read addr=%0d got=%0h exp=%0h", a, rd_data, 8'h10 + 8'(a));
            end
        end
    endtask

    task automatic test_early_stop();
        logic [3:0] addrs [3] = '{4'd0, 4'd4, 4'd5};
        logic [7:0] exps  [3] = '{8'h40, 8'h44, 8'h15};
        pulse_start();
        run_ticks(5, 8'h40);
        rec_stop = 1'b1;
        step();
        rec_stop = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL early_done got=%0b exp=1", done); end
        step();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL early_done_once got=%0b exp=0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL early_busy got=%0b exp=0", busy); end
        checks++; if (rec_len !== 5'd5) begin failures++; $display("FAIL early_len got=%0d exp=5", rec_len); end
        for (int i = 0; i < 3; i++) begin
            rd_addr = addrs[i];
            step();
            checks++;
            if (rd_data !== exps[i]) begin
                failures++;
                $display("FAIL early_read addr=%0d got=%0h exp=%0h", addrs[i], rd_data, exps[i]);
            end
        end
    endtask

    task automatic test_stop_on_tick();
        logic [3:0] addrs [2] = '{4'd2, 4'd3};
        logic [7:0] exps  [2] = '{8'h62, 8'h43};
        pulse_start();
        run_ticks(3, 8'h60);
        wait_tick_cycle();
        sample = 8'h99;
        rec_stop = 1'b1;
        step();
        rec_stop = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL tickstop_done got=%0b exp=1", done); end
        checks++; if (rec_len !== 5'd3) begin failures++; $display("FAIL tickstop_len got=%0d exp=3", rec_len); end
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tickstop_busy got=%0b exp=0", busy); end
        for (int i = 0; i < 2; i++) begin
            rd_addr = addrs[i];
            step();
            checks++;
            if (rd_data !== exps[i]) begin
                failures++;
                $display("FAIL tickstop_read addr=%0d got=%0h exp=%0h", addrs[i], rd_data, exps[i]);
            end
        end
    endtask

    task automatic test_start_stop_same();
        int pulses = 0;
        int busy_seen = 0;
        rec_start = 1'b1;
        rec_stop = 1'b1;
        step();
        rec_start = 1'b0;
        rec_stop = 1'b0;
        for (int i = 0; i < 2 * CLK_DIV; i++) begin
            if (done) pulses++;
            if (busy) busy_seen++;
            step();
        end
        checks++; if (busy_seen != 0) begin failures++; $display("FAIL same_busy got=%0d cycles exp=0", busy_seen); end
        checks++; if (pulses != 0) begin failures++; $display("FAIL same_done got=%0d pulses exp=0", pulses); end
        checks++; if (rec_len !== 5'd3) begin failures++; $display("FAIL same_len got=%0d exp=3", rec_len); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        logic [3:0] addrs [3] = '{4'd0, 4'd1, 4'd2};
        logic [7:0] exps  [3] = '{8'h30, 8'h31, 8'h72};
        pulse_start();
        run_ticks(7, 8'h70);
        checks++; if (rec_len !== 5'd7) begin failures++; $display("FAIL rstmid_len_pre got=%0d exp=7", rec_len); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (rec_len !== 5'd0) begin failures++; $display("FAIL rstmid_len got=%0d exp=0", rec_len); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL rstmid_rd got=%0h exp=0", rd_data); end
        for (int i = 0; i < 2 * CLK_DIV; i++) begin
            if (done) pulses++;
            step();
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL rstmid_done got=%0d pulses exp=0", pulses); end
        checks++; if (rec_len !== 5'd0) begin failures++; $display("FAIL rstmid_idle_len got=%0d exp=0", rec_len); end
        pulse_start();
        run_ticks(2, 8'h30);
        rec_stop = 1'b1;
        step();
        rec_stop = 1'b0;
        checks++; if (rec_len !== 5'd2) begin failures++; $display("FAIL rstmid_newlen got=%0d exp=2", rec_len); end
        for (int i = 0; i < 3; i++) begin
            rd_addr = addrs[i];
            step();
            checks++;
            if (rd_data !== exps[i]) begin
                failures++;
                $display("FAIL rstmid_read addr=%0d got=%0h exp=%0h", addrs[i], rd_data, exps[i]);
            end
        end
    endtask

`ifdef AUDIO_REC_TRIGGER_EN
    task automatic test_trigger();
        thresh = 7'h20;
        sample = 8'h80;
        pulse_start();
        for (int i = 0; i < 10 * CLK_DIV; i++) step();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL trig_armed_busy got=%0b exp=1", busy); end
        checks++; if (rec_len !== 5'd0) begin failures++; $display("FAIL trig_armed_len got=%0d exp=0", rec_len); end
        wait_tick_cycle();
        sample = 8'hA5;
        step();
        checks++; if (rec_len !== 5'd1) begin failures++; $display("FAIL trig_len got=%0d exp=1", rec_len); end
        run_ticks(1, 8'h11);
        rec_stop = 1'b1;
        step();
        rec_stop = 1'b0;
        rd_addr = 4'd0;
        step();
        checks++; if (rd_data !== 8'hA5) begin failures++; $display("FAIL trig_read0 got=%0h exp=a5", rd_data); end
        rd_addr = 4'd1;
        step();
        checks++; if (rd_data !== 8'h11) begin failures++; $display("FAIL trig_read1 got=%0h exp=11", rd_data); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_early_stop();
        test_stop_on_tick();
        test_start_stop_same();
        test_reset_mid();
`ifdef AUDIO_REC_TRIGGER_EN
        test_trigger();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
